// File: rtl/button_event_engine.sv
`default_nettype none
// ============================================================================
// Module   : button_event_engine
// Purpose  : Per-channel debounced pushbutton classifier (short/long/double/repeat/held).
// Revision : 1.0
// ============================================================================
module button_event_engine #(
    parameter int N_BTN         = 2,
    parameter int DEBOUNCE_MS   = 5,
    parameter int LONG_MS       = 1000,
    parameter int DBL_WINDOW_MS = 300,
    parameter int REPEAT_MS     = 200
) (
    input  logic             clk_1khz_i,
    input  logic             rst_n_i,
    input  logic [N_BTN-1:0] pushbutton_i,
    output logic [N_BTN-1:0] short_o,
    output logic [N_BTN-1:0] long_o,
    output logic [N_BTN-1:0] double_o,
    output logic [N_BTN-1:0] repeat_o,
    output logic [N_BTN-1:0] held_o
);

    localparam int c_max_a = (LONG_MS > DBL_WINDOW_MS) ? LONG_MS : DBL_WINDOW_MS;
    localparam int c_max_b = (c_max_a > REPEAT_MS) ? c_max_a : REPEAT_MS;
    localparam int c_max_t = (c_max_b > DEBOUNCE_MS) ? c_max_b : DEBOUNCE_MS;
    localparam int c_cw    = $clog2(c_max_t) + 1;

    localparam logic [c_cw-1:0] c_one       = c_cw'(1);
    localparam logic [c_cw-1:0] c_sat       = {c_cw{1'b1}};
    localparam logic [c_cw-1:0] c_deb_last  = c_cw'(DEBOUNCE_MS - 1);
    localparam logic [c_cw-1:0] c_long_last = c_cw'(LONG_MS - 1);
    localparam logic [c_cw-1:0] c_dbl       = c_cw'(DBL_WINDOW_MS);
    localparam logic [c_cw-1:0] c_rep       = c_cw'(REPEAT_MS);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRESSED   = 3'd1,
        ST_LONG_HELD = 3'd2,
        ST_WAIT_DBL  = 3'd3,
        ST_SECOND    = 3'd4
    } state_t;

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
        logic            r_sync1, r_sync2, r_deb;
        logic [c_cw-1:0] r_dcnt;
        logic [c_cw-1:0] r_tmr;
        logic [c_cw-1:0] w_tmr_inc;
        state_t          r_state;
        logic            r_short, r_long, r_double, r_repeat, r_held;

        // One timer serves hold, window and repeat timing; each state clears it on entry.
        assign w_tmr_inc = (r_tmr == c_sat) ? r_tmr : r_tmr + c_one;

        always_ff @(posedge clk_1khz_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_deb   <= 1'b0;
                r_dcnt  <= '0;
            end else begin
                r_sync1 <= pushbutton_i[gi];
                r_sync2 <= r_sync1;
                if (r_sync2 == r_deb) begin
                    r_dcnt <= '0;
                end else if (r_dcnt >= c_deb_last) begin
                    r_deb  <= r_sync2;
                    r_dcnt <= '0;
                end else begin
                    r_dcnt <= r_dcnt + c_one;
                end
            end
        end

        always_ff @(posedge clk_1khz_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                r_state  <= ST_IDLE;
                r_tmr    <= '0;
                r_short  <= 1'b0;
                r_long   <= 1'b0;
                r_double <= 1'b0;
                r_repeat <= 1'b0;
                r_held   <= 1'b0;
            end else begin
                r_short  <= 1'b0;
                r_long   <= 1'b0;
                r_double <= 1'b0;
                r_repeat <= 1'b0;
                r_held   <= 1'b0;
                case (r_state)
                    ST_IDLE: begin
                        r_tmr <= '0;
                        if (r_deb) r_state <= ST_PRESSED;
                    end
                    ST_PRESSED: begin
                        // Threshold is tested before release so a coincident fall still reports long.
                        if (w_tmr_inc >= c_long_last) begin
                            r_long  <= 1'b1;
                            r_tmr   <= '0;
                            r_held  <= r_deb;
                            r_state <= r_deb ? ST_LONG_HELD : ST_IDLE;
                        end else if (!r_deb) begin
                            r_tmr <= '0;
                            if (DBL_WINDOW_MS == 0) begin
                                r_short <= 1'b1;
                                r_state <= ST_IDLE;
                            end else begin
                                r_state <= ST_WAIT_DBL;
                            end
                        end else begin
                            r_tmr <= w_tmr_inc;
                        end
                    end
                    ST_LONG_HELD: begin
                        if (!r_deb) begin
                            r_tmr   <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_held <= 1'b1;
                            if ((REPEAT_MS > 0) && (w_tmr_inc >= c_rep)) begin
                                r_repeat <= 1'b1;
                                r_tmr    <= '0;
                            end else begin
                                r_tmr <= w_tmr_inc;
                            end
                        end
                    end
                    ST_WAIT_DBL: begin
                        if (r_deb) begin
                            r_double <= 1'b1;
                            r_tmr    <= '0;
                            r_state  <= ST_SECOND;
                        end else if (w_tmr_inc >= c_dbl) begin
                            r_short <= 1'b1;
                            r_tmr   <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_tmr <= w_tmr_inc;
                        end
                    end
                    ST_SECOND: begin
                        r_tmr <= '0;
                        if (!r_deb) r_state <= ST_IDLE;
                    end
                    default: begin
                        r_tmr   <= '0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end

        assign short_o[gi]  = r_short;
        assign long_o[gi]   = r_long;
        assign double_o[gi] = r_double;
        assign repeat_o[gi] = r_repeat;
        assign held_o[gi]   = r_held;
    end

endmodule
`default_nettype wire

// File: tb/tb_button_event_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_event_engine
// Purpose  : Directed self-checking bench for button_event_engine at default timing.
// Revision : 1.0
// ============================================================================
module tb_button_event_engine;

    localparam int DEB  = 5;
    localparam int LONG = 1000;
    localparam int DBL  = 300;
    localparam int REP  = 200;
    // Input edge to visible debounced level: two synchronizer flops plus DEB stable cycles.
    localparam int LAT  = 2 + DEB;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] pb    = 2'b00;
    logic [1:0] short_o, long_o, double_o, repeat_o, held_o;

    button_event_engine dut (
        .clk_1khz_i   (clk),
        .rst_n_i      (rst_n),
        .pushbutton_i (pb),
        .short_o      (short_o),
        .long_o       (long_o),
        .double_o     (double_o),
        .repeat_o     (repeat_o),
        .held_o       (held_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_short[2], n_long[2], n_dbl[2], n_rep[2], n_excl;
    int t_short[2], t_long[2], t_dbl[2], t_rep[2], t_rep_prev[2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (short_o[i])  begin n_short[i]++; t_short[i] = cyc; end
            if (long_o[i])   begin n_long[i]++;  t_long[i]  = cyc; end
            if (double_o[i]) begin n_dbl[i]++;   t_dbl[i]   = cyc; end
            if (repeat_o[i]) begin
                n_rep[i]++;
                t_rep_prev[i] = t_rep[i];
                t_rep[i]      = cyc;
            end
            if ((int'(short_o[i]) + int'(long_o[i]) + int'(double_o[i]) + int'(repeat_o[i])) > 1)
                n_excl++;
        end
    end

    int checks = 0;
    int errors = 0;
    int b_short[2], b_long[2], b_dbl[2], b_rep[2];

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        for (int i = 0; i < 2; i++) begin
            b_short[i] = n_short[i];
            b_long[i]  = n_long[i];
            b_dbl[i]   = n_dbl[i];
            b_rep[i]   = n_rep[i];
        end
    endtask

    task automatic press(input int ch, input int len, output int p, output int r);
        pb[ch] = 1'b1;
        p      = cyc;
        cycles(len);
        pb[ch] = 1'b0;
        r      = cyc;
    endtask

    task automatic bouncy_press(input int ch, input int stable, output int r);
        for (int k = 0; k < 3; k++) begin
            pb[ch] = 1'b1; cycles(1);
            pb[ch] = 1'b0; cycles(1);
        end
        pb[ch] = 1'b1;
        cycles(stable);
        for (int k = 0; k < 3; k++) begin
            pb[ch] = 1'b0; cycles(1);
            pb[ch] = 1'b1; cycles(1);
        end
        pb[ch] = 1'b0;
        r      = cyc;
    endtask

    initial begin
        int p, r, p2, r2, q;

        cycles(3);
        check("reset_outputs", int'({short_o, long_o, double_o, repeat_o, held_o}), 0);
        rst_n = 1'b1;
        cycles(10);

        // Bouncing short press: one short pulse one window after debounced release.
        snap();
        bouncy_press(0, 25, r);
        cycles(400);
        check("t1_short_cnt", n_short[0] - b_short[0], 1);
        check_rng("t1_short_time", t_short[0], r + LAT + DBL - 2, r + LAT + DBL + 4);
        check("t1_long_cnt", n_long[0] - b_long[0], 0);
        check("t1_dbl_cnt", n_dbl[0] - b_dbl[0], 0);
        check("t1_rep_cnt", n_rep[0] - b_rep[0], 0);

        // 1500 ms hold: long, two repeats, held level, no short.
        snap();
        pb[0] = 1'b1;
        p     = cyc;
        cycles(700);
        check("t2_held_early", int'(held_o[0]), 0);
        cycles(800);
        check("t2_held_mid", int'(held_o[0]), 1);
        pb[0] = 1'b0;
        cycles(30);
        check("t2_held_after", int'(held_o[0]), 0);
        cycles(400);
        check("t2_long_cnt", n_long[0] - b_long[0], 1);
        check("t2_long_time", t_long[0], p + LAT + LONG);
        check("t2_rep_cnt", n_rep[0] - b_rep[0], 2);
        check("t2_rep1_time", t_rep_prev[0], p + LAT + LONG + REP);
        check("t2_rep2_time", t_rep[0], p + LAT + LONG + 2 * REP);
        check("t2_short_cnt", n_short[0] - b_short[0], 0);

        // Two 30 ms presses, 100 ms gap: one double, no short.
        snap();
        press(0, 30, p, r);
        cycles(100);
        press(0, 30, p2, r2);
        cycles(500);
        check("t3_dbl_cnt", n_dbl[0] - b_dbl[0], 1);
        check("t3_dbl_time", t_dbl[0], p2 + LAT + 1);
        check("t3_short_cnt", n_short[0] - b_short[0], 0);
        check("t3_long_cnt", n_long[0] - b_long[0], 0);

        // Two 30 ms presses, 400 ms gap: two shorts, no double.
        snap();
        press(0, 30, p, r);
        cycles(400);
        press(0, 30, p2, r2);
        cycles(500);
        check("t4_short_cnt", n_short[0] - b_short[0], 2);
        check("t4_short2_time", t_short[0], r2 + LAT + 1 + DBL);
        check("t4_dbl_cnt", n_dbl[0] - b_dbl[0], 0);

        // Channel independence: ch0 long hold while ch1 gets a short tap.
        snap();
        pb[0] = 1'b1;
        p     = cyc;
        cycles(200);
        press(1, 30, p2, r2);
        cycles(1270);
        pb[0] = 1'b0;
        cycles(400);
        check("t5_ch0_long_cnt", n_long[0] - b_long[0], 1);
        check("t5_ch0_long_time", t_long[0], p + LAT + LONG);
        check("t5_ch0_rep_cnt", n_rep[0] - b_rep[0], 2);
        check("t5_ch0_short_cnt", n_short[0] - b_short[0], 0);
        check("t5_ch1_short_cnt", n_short[1] - b_short[1], 1);
        check("t5_ch1_long_cnt", n_long[1] - b_long[1], 0);
        check("t5_ch1_dbl_cnt", n_dbl[1] - b_dbl[1], 0);

        // Reset mid-hold with the button kept down: restart as a fresh press.
        pb[0] = 1'b1;
        cycles(1100);
        check("t6_held_pre_rst", int'(held_o[0]), 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_async", int'({short_o, long_o, double_o, repeat_o, held_o}), 0);
        for (int k = 0; k < 3; k++) begin
            cycles(1);
            check("t6_rst_cycle", int'({short_o, long_o, double_o, repeat_o, held_o}), 0);
        end
        rst_n = 1'b1;
        q     = cyc;
        snap();
        cycles(1100);
        check("t6_long_cnt", n_long[0] - b_long[0], 1);
        check("t6_long_time", t_long[0], q + LAT + LONG);
        check("t6_held_post", int'(held_o[0]), 1);
        pb[0] = 1'b0;
        cycles(50);
        check("t6_held_release", int'(held_o[0]), 0);
        check("t6_short_cnt", n_short[0] - b_short[0], 0);

        check("event_exclusive", n_excl, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
